// File: rtl/nibble_add_sched.sv
// nibble_add_sched
// Sequencer and round-robin arbiter for one shared 4-bit ripple adder. The
// adder sits outside this block. This block feeds it one nibble per clock and
// builds a W-bit sum, where W = 4*NIBBLES.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   req0/a0/b0/cin0   requester 0 request and operands (held until gnt0)
//   req1/a1/b1/cin1   requester 1 request and operands (held until gnt1)
//   gnt0, gnt1        combinational accept pulses, only while IDLE
//   busy              high whenever the sequencer is not IDLE
//   done, done_id     one-cycle completion pulse and the requester it served
//   result, cout      registered sum and final carry, held until next done
//   add_a/add_b/add_cin  nibble operands and carry driven to the adder
//   add_sum/add_cout     combinational adder response
module nibble_add_sched #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         cin0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic         cin1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         busy,
  output logic         done,
  output logic         done_id,
  output logic [W-1:0] result,
  output logic         cout,
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_cin,
  input  logic [3:0]   add_sum,
  input  logic         add_cout
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [W-1:0]    opa_q;
  logic [W-1:0]    opb_q;
  logic            cinL_q;
  logic            id_q;
  logic            lastServed_q;
  logic [IW-1:0]   idx_q;
  logic            carry_q;
  logic [W-1:0]    shadow_q;
  logic [W-1:0]    shadow_d;
  logic            busy_q;
  logic            done_q;
  logic            doneId_q;
  logic [W-1:0]    result_q;
  logic            cout_q;
  logic            gnt0_c;
  logic            gnt1_c;
  logic            lastNibble;

  // Grant decision plus adder drive. On a tie, the requester that was not
  // served last wins. The shadow word is merged with the current adder nibble
  // so the final nibble can go straight into result on the last RUN edge.
  always_comb begin
    gnt0_c     = 1'b0;
    gnt1_c     = 1'b0;
    add_a      = 4'h0;
    add_b      = 4'h0;
    add_cin    = 1'b0;
    shadow_d   = shadow_q;
    lastNibble = (idx_q == IW'(NIBBLES - 1));
    if (state_q == IDLE) begin
      if (req0 && req1) begin
        gnt0_c = lastServed_q;
        gnt1_c = ~lastServed_q;
      end else begin
        gnt0_c = req0;
        gnt1_c = req1;
      end
    end
    if (state_q == RUN) begin
      add_a   = opa_q[{idx_q, 2'b00} +: 4];
      add_b   = opb_q[{idx_q, 2'b00} +: 4];
      add_cin = (idx_q == '0) ? cinL_q : carry_q;
      shadow_d[{idx_q, 2'b00} +: 4] = add_sum;
    end
  end

  // Sequencer: accept in IDLE, walk nibbles in RUN, pulse done for one cycle.
  // A reset in any state abandons the operation without producing a done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      opa_q        <= '0;
      opb_q        <= '0;
      cinL_q       <= 1'b0;
      id_q         <= 1'b0;
      lastServed_q <= 1'b1;
      idx_q        <= '0;
      carry_q      <= 1'b0;
      shadow_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      doneId_q     <= 1'b0;
      result_q     <= '0;
      cout_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt0_c || gnt1_c) begin
            opa_q        <= gnt1_c ? a1 : a0;
            opb_q        <= gnt1_c ? b1 : b0;
            cinL_q       <= gnt1_c ? cin1 : cin0;
            id_q         <= gnt1_c;
            lastServed_q <= gnt1_c;
            idx_q        <= '0;
            busy_q       <= 1'b1;
            state_q      <= RUN;
          end
        end
        RUN: begin
          shadow_q <= shadow_d;
          carry_q  <= add_cout;
          if (lastNibble) begin
            result_q <= shadow_d;
            cout_q   <= add_cout;
            done_q   <= 1'b1;
            doneId_q <= id_q;
            state_q  <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt0    = gnt0_c;
  assign gnt1    = gnt1_c;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = doneId_q;
  assign result  = result_q;
  assign cout    = cout_q;

endmodule
